// File: rtl/ble_packet_sync_ctrl.sv
// BLE receive sequencer: symbol re-timing, access-address search, header parse
// and byte streaming of header, payload and CRC to the downstream sink.
module ble_packet_sync_ctrl #(
  parameter int          SAMPLE_RATE = 16,
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter int          AA_WINDOW   = 40,
  parameter int          MAX_LEN     = 37,
  parameter int          CRC_BYTES   = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       data_bit,
  input  logic       preamble_detected,
  input  logic       abort,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_last,
  output logic       aa_matched,
  output logic       pkt_done,
  output logic       pkt_error,
  output logic       busy
);

  localparam int PH_W  = $clog2(SAMPLE_RATE);
  localparam int WIN_W = $clog2(AA_WINDOW + 1);
  localparam logic [PH_W-1:0]  STROBE_PH = PH_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SAMPLE_RATE - 1);
  localparam logic [WIN_W-1:0] WIN_LIMIT = WIN_W'(AA_WINDOW);

  typedef enum logic [1:0] {IDLE, AA_SEARCH, HEADER, PAYLOAD} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [31:0]       aa_sr_q, aa_sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        byte_sr_q, byte_sr_d;
  logic              hdr_idx_q, hdr_idx_d;
  logic [8:0]        rem_q, rem_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;
  logic              byte_last_q, byte_last_d;
  logic              aa_matched_q, aa_matched_d;
  logic              pkt_done_q, pkt_done_d;
  logic              pkt_error_q, pkt_error_d;
  logic              busy_q, busy_d;

  logic        strobe;
  logic [31:0] aa_shift;
  logic [7:0]  byte_shift;

  assign strobe     = en && (state_q != IDLE) && (phase_q == STROBE_PH);
  assign aa_shift   = {data_bit, aa_sr_q[31:1]};
  assign byte_shift = {data_bit, byte_sr_q[7:1]};

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    win_d        = win_q;
    aa_sr_d      = aa_sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_sr_d    = byte_sr_q;
    hdr_idx_d    = hdr_idx_q;
    rem_d        = rem_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    byte_last_d  = 1'b0;
    aa_matched_d = 1'b0;
    pkt_done_d   = 1'b0;
    pkt_error_d  = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      byte_out_d = 8'd0;
    end else if (en) begin
      if (state_q != IDLE)
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      case (state_q)
        IDLE: begin
          if (preamble_detected) begin
            state_d   = AA_SEARCH;
            phase_d   = '0;
            win_d     = '0;
            aa_sr_d   = '0;
            bit_cnt_d = '0;
            byte_sr_d = '0;
            hdr_idx_d = 1'b0;
          end
        end
        AA_SEARCH: begin
          if (strobe) begin
            aa_sr_d = aa_shift;
            win_d   = win_q + WIN_W'(1);
            if (aa_shift == ACCESS_ADDR) begin
              aa_matched_d = 1'b1;
              state_d      = HEADER;
            end else if (win_q + WIN_W'(1) == WIN_LIMIT) begin
              state_d = IDLE;
            end
          end
        end
        HEADER: begin
          if (strobe) begin
            byte_sr_d = byte_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!hdr_idx_q) begin
                byte_valid_d = 1'b1;
                byte_out_d   = byte_shift;
                hdr_idx_d    = 1'b1;
              end else if ({1'b0, byte_shift} > 9'(MAX_LEN)) begin
                // Oversized length byte is swallowed; only the error is reported
                pkt_error_d = 1'b1;
                state_d     = IDLE;
              end else begin
                byte_valid_d = 1'b1;
                byte_out_d   = byte_shift;
                rem_d        = {1'b0, byte_shift} + 9'(CRC_BYTES);
                state_d      = PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (strobe) begin
            byte_sr_d = byte_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_valid_d = 1'b1;
              byte_out_d   = byte_shift;
              rem_d        = rem_q - 9'd1;
              if (rem_q == 9'd1) begin
                byte_last_d = 1'b1;
                pkt_done_d  = 1'b1;
                state_d     = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      win_q        <= '0;
      aa_sr_q      <= '0;
      bit_cnt_q    <= '0;
      byte_sr_q    <= '0;
      hdr_idx_q    <= 1'b0;
      rem_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      aa_matched_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_error_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      win_q        <= win_d;
      aa_sr_q      <= aa_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_sr_q    <= byte_sr_d;
      hdr_idx_q    <= hdr_idx_d;
      rem_q        <= rem_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      aa_matched_q <= aa_matched_d;
      pkt_done_q   <= pkt_done_d;
      pkt_error_q  <= pkt_error_d;
      busy_q       <= busy_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign aa_matched = aa_matched_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_error  = pkt_error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ble_packet_sync_ctrl.sv
// Scenario bench for ble_packet_sync_ctrl: expected bytes are queued as they are
// transmitted and checked by a monitor when the DUT strobes them out.
module tb_ble_packet_sync_ctrl;
  localparam int SR = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       data_bit = 1'b0;
  logic       preamble_detected = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, byte_last, aa_matched, pkt_done, pkt_error, busy;

  ble_packet_sync_ctrl #(.SAMPLE_RATE(SR)) dut (
    .clk(clk), .resetn(resetn), .en(en), .data_bit(data_bit),
    .preamble_detected(preamble_detected), .abort(abort),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
    .aa_matched(aa_matched), .pkt_done(pkt_done), .pkt_error(pkt_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] b; logic last;} exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  frame[$];
  logic [31:0] aa_word = 32'h8E89BED6;
  int compared = 0;
  int mismatched = 0;
  int aa_cnt, done_cnt, err_cnt;
  int cyc = 0;
  int last_bv_cyc;
  bit have_prev;
  int gap_chk;
  int period = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (aa_matched) aa_cnt++;
    if (pkt_error) err_cnt++;
    if (pkt_done) done_cnt++;
    if (byte_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_byte got %02h want no byte", byte_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (byte_out !== mon_e.b || byte_last !== mon_e.last || pkt_done !== mon_e.last) begin
          mismatched++;
          $display("FAIL byte got %02h last=%0b done=%0b want %02h last=%0b done=%0b",
                   byte_out, byte_last, pkt_done, mon_e.b, mon_e.last, mon_e.last);
        end
      end
      if (gap_chk != 0 && have_prev) begin
        compared++;
        if (cyc - last_bv_cyc != gap_chk) begin
          mismatched++;
          $display("FAIL byte_spacing got %0d want %0d", cyc - last_bv_cyc, gap_chk);
        end
      end
      have_prev   = 1'b1;
      last_bv_cyc = cyc;
    end else if (byte_last || pkt_done) begin
      compared++;
      mismatched++;
      $display("FAIL stray_last got last=%0b done=%0b want 0 without byte_valid", byte_last, pkt_done);
    end
  end

  task automatic en_cycle();
    for (int k = 0; k < period - 1; k++) begin
      en = 1'b0;
      @(posedge clk); #1;
    end
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic v);
    data_bit = v;
    repeat (SR) en_cycle();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push, input bit last);
    if (push) exp_q.push_back({b, last});
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_preamble();
    data_bit = 1'b0;
    preamble_detected = 1'b1;
    en_cycle();
    preamble_detected = 1'b0;
  endtask

  task automatic send_aa();
    for (int i = 0; i < 32; i++) send_bit(aa_word[i]);
  endtask

  task automatic send_frame();
    send_preamble();
    send_aa();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 1'b1, i == frame.size() - 1);
  endtask

  task automatic idle(input int n);
    data_bit = 1'b0;
    repeat (n) en_cycle();
  endtask

  task automatic start_test();
    exp_q.delete();
    aa_cnt = 0; done_cnt = 0; err_cnt = 0;
    have_prev = 1'b0; gap_chk = 0; period = 1;
  endtask

  task automatic check_end(input string name, input int want_aa, input int want_done,
                           input int want_err);
    compared++;
    if (aa_cnt !== want_aa) begin
      mismatched++; $display("FAIL %s_aa_count got %0d want %0d", name, aa_cnt, want_aa);
    end
    compared++;
    if (done_cnt !== want_done) begin
      mismatched++; $display("FAIL %s_done_count got %0d want %0d", name, done_cnt, want_done);
    end
    compared++;
    if (err_cnt !== want_err) begin
      mismatched++; $display("FAIL %s_err_count got %0d want %0d", name, err_cnt, want_err);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL %s_busy_end got %0b want 0", name, busy);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++; $display("FAIL %s_missing_bytes got %0d left want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    start_test();
    resetn = 1'b0; en = 1'b1; preamble_detected = 1'b1; data_bit = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    compared++;
    if ({byte_out, byte_valid, byte_last, aa_matched, pkt_done, pkt_error, busy} !== 14'd0) begin
      mismatched++;
      $display("FAIL reset_outputs got %02h %0b%0b%0b%0b%0b%0b want all 0", byte_out,
               byte_valid, byte_last, aa_matched, pkt_done, pkt_error, busy);
    end
    preamble_detected = 1'b0; data_bit = 1'b0; en = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    start_test();
    gap_chk = 8 * SR;
    frame = '{8'h02, 8'h05, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hAA, 8'hBB, 8'hCC};
    send_preamble();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL nominal_busy_start got %0b want 1", busy);
    end
    send_aa();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 1'b1, i == frame.size() - 1);
    idle(4);
    check_end("nominal", 1, 1, 0);
  endtask

  task automatic test_aa_timeout();
    start_test();
    send_preamble();
    for (int i = 0; i < 39; i++) send_bit(i % 2 == 0);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL timeout_busy_39 got %0b want 1", busy);
    end
    send_bit(1'b0);
    check_end("timeout", 0, 0, 0);
  endtask

  task automatic test_len_error();
    start_test();
    send_preamble();
    send_aa();
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h30, 1'b0, 1'b0);
    idle(4);
    check_end("len_error", 1, 0, 1);
  endtask

  task automatic test_zero_len();
    start_test();
    frame = '{8'h01, 8'h00, 8'h5A, 8'hC3, 8'h7E};
    send_preamble();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL zero_len_restart_busy got %0b want 1", busy);
    end
    send_aa();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 1'b1, i == frame.size() - 1);
    idle(4);
    check_end("zero_len", 1, 1, 0);
  endtask

  task automatic test_en_gating();
    start_test();
    period = 3;
    gap_chk = 8 * SR * 3;
    frame = '{8'h02, 8'h05, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hAA, 8'hBB, 8'hCC};
    send_frame();
    idle(4);
    check_end("en_gating", 1, 1, 0);
    period = 1;
  endtask

  task automatic test_interrupt(input bit use_abort);
    string name;
    logic [7:0] b;
    start_test();
    name = use_abort ? "abort" : "mid_reset";
    b = 8'h13;
    send_preamble();
    send_aa();
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    if (use_abort) begin
      abort = 1'b1; en = 1'b0;
    end else begin
      resetn = 1'b0; en = 1'b1;
    end
    @(posedge clk); #1;
    abort = 1'b0; resetn = 1'b1;
    compared++;
    if ({byte_valid, byte_last, aa_matched, pkt_done, pkt_error, busy} !== 6'd0) begin
      mismatched++;
      $display("FAIL %s_outputs got %0b%0b%0b%0b%0b%0b want 000000", name, byte_valid,
               byte_last, aa_matched, pkt_done, pkt_error, busy);
    end
    if (!use_abort) begin
      compared++;
      if (byte_out !== 8'd0) begin
        mismatched++; $display("FAIL mid_reset_byte_out got %02h want 00", byte_out);
      end
    end
    for (int i = 4; i < 8; i++) send_bit(b[i]);
    idle(8 * SR);
    check_end(name, 1, 0, 0);
  endtask

  task automatic test_preamble_in_header();
    logic [7:0] h;
    start_test();
    h = 8'h02;
    frame = '{8'h05, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hAA, 8'hBB, 8'hCC};
    send_preamble();
    send_aa();
    exp_q.push_back({h, 1'b0});
    for (int i = 0; i < 8; i++) begin
      data_bit = h[i];
      preamble_detected = (i == 2);
      en_cycle();
      preamble_detected = 1'b0;
      repeat (SR - 1) en_cycle();
    end
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 1'b1, i == frame.size() - 1);
    idle(4);
    check_end("preamble_in_header", 1, 1, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_aa_timeout();
    test_len_error();
    test_zero_len();
    test_en_gating();
    test_interrupt(1'b0);
    test_interrupt(1'b1);
    test_preamble_in_header();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ble_packet_sync_ctrl.md
Name: ble_packet_sync_ctrl

Overview:
- Receive sequencer placed directly after the preamble detector.
- Re-times the sample-rate matched-filter bit stream into symbols, searches for the access address and parses the 2-byte PDU header.
- Streams header, payload and CRC bytes to the downstream byte sink.
- Drives packet done/error status for the link-layer logic.

Parameters:
- SAMPLE_RATE, 16, samples per symbol; even, ≥4.
- ACCESS_ADDR, 32'h8E89BED6, access address to match; received LSB first.
- AA_WINDOW, 40, bit strobes allowed in AA_SEARCH before giving up.
- MAX_LEN, 37, largest legal header length field.
- CRC_BYTES, 3, trailing bytes streamed after the payload.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous active-low reset.
- en  input  1  sample-rate enable, shared with the preamble detector.
- data_bit  input  1  matched-filter bit at sample rate.
- preamble_detected  input  1  preamble-detector output pulse.
- abort  input  1  forces a return to IDLE.
- byte_out  output  8  assembled byte, LSB = first received bit.
- byte_valid  output  1  one-cycle strobe; byte_out is valid.
- byte_last  output  1  qualifies byte_valid on the final CRC byte.
- aa_matched  output  1  one-cycle pulse when the access address matches.
- pkt_done  output  1  one-cycle pulse after the last byte.
- pkt_error  output  1  one-cycle pulse when the length exceeds MAX_LEN.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: resetn is synchronous, active-low; sampled only on posedge clk.
  - While resetn=0: state=IDLE; all counters and shift registers = 0; all outputs = 0.
  - Reset mid-packet discards the packet; no pkt_done and no pkt_error are issued.
- All state advance, counting and sampling occurs only on cycles with en=1. Outputs are registered. Strobes last exactly one clk cycle and are cleared on the next cycle, even if en=0.
- Symbol timing:
  - The phase counter (width clog2(SAMPLE_RATE)) loads 0 on the en cycle that causes IDLE->AA_SEARCH.
  - It then increments mod SAMPLE_RATE on every en cycle.
  - A bit strobe occurs on the en cycle where the pre-increment value equals SAMPLE_RATE/2-1. data_bit on that cycle is the symbol value.
  - With en held high, the first strobe is SAMPLE_RATE/2 cycles after the transition and later strobes are every SAMPLE_RATE cycles.
- States:
  - IDLE: on en & preamble_detected, go to AA_SEARCH. Clear the 32-bit AA shift register and the window counter.
  - AA_SEARCH: on each strobe, shift data_bit in at bit 31 (right shift) and increment the window counter.
    - If the post-shift register equals ACCESS_ADDR: pulse aa_matched and go to HEADER. This takes 32 strobes minimum.
    - Otherwise, when the window counter reaches AA_WINDOW: go to IDLE silently.
  - HEADER: collect 16 bits and emit 2 bytes. Byte 1 (bits 15:8) is the length L.
    - On the strobe completing byte 1: if L > MAX_LEN, pulse pkt_error with no byte_valid for that byte, then go to IDLE. Otherwise go to PAYLOAD.
  - PAYLOAD: emit L + CRC_BYTES bytes.
    - The remaining-byte counter is 9 bits, loaded with L + CRC_BYTES and decremented per emitted byte.
    - The last byte asserts byte_valid, byte_last and pkt_done together in one cycle, then returns to IDLE.
    - L=0 emits CRC_BYTES bytes only.
- Byte assembly: 3-bit bit counter plus 8-bit right-shift register. byte_valid is asserted in the clk cycle after the strobe that delivers the 8th bit.
- preamble_detected outside IDLE is ignored; a packet in progress is never restarted.
- abort=1 (sampled regardless of en) goes to IDLE at the next edge.
  - No pkt_done or pkt_error is issued.
  - A byte_valid already registered on that edge still completes.
  - abort has lower priority than resetn.
- en=0 freezes all state and counters; strobes may not occur.
- busy=1 in AA_SEARCH, HEADER and PAYLOAD.

Test Plan:
- Nominal: SAMPLE_RATE=16, en=1, preamble pulse, then AA 0x8E89BED6 LSB-first, header 0x02,0x05, payload 0x11..0x15, CRC 0xAA,0xBB,0xCC, each bit held 16 samples.
  - Required: aa_matched pulses once.
  - 10 byte_valid strobes: 02,05,11,12,13,14,15,AA,BB,CC.
  - byte_last and pkt_done on CC; busy falls after it.
- AA timeout: preamble pulse, then 40 bits of 0x55 pattern -> no aa_matched; busy=0 after the 40th strobe; no byte_valid.
- Length error: valid AA, header 0x02,0x30 (48 > 37).
  - Required: byte_valid for 0x02 only; pkt_error pulses once; state returns to IDLE.
  - A new preamble pulse is accepted afterwards.
- Zero length: header 0x01,0x00 -> 5 bytes total (01,00 plus 3 CRC); pkt_done on byte 5.
- en gating: repeat the nominal case with en high 1 cycle in 3 -> identical byte sequence; strobes spaced 48 clk cycles.
- Interrupts and ignored input:
  - resetn=0 for 1 cycle during PAYLOAD byte 3 -> IDLE next cycle; no pkt_done; all outputs 0.
  - Same test with abort -> same result.
  - preamble_detected pulsed during HEADER -> ignored; packet completes normally.
